hex2dec_arbiter: RTL and testbench



---
 rtl/hex2dec_pkg.sv | 17 +
 rtl/hex2dec_arbiter_byte_fifo.sv | 57 +++++
 rtl/hex2dec_arbiter.sv | 160 ++++++++++++++++
 tb/tb_hex2dec_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex2dec_pkg.sv
// rtl/hex2dec_pkg.sv - shared types and constants for the hex2dec arbiter
package hex2dec_pkg;

   typedef enum logic [1:0] {IDLE, START, COLLECT, RELEASE} arb_state_t;

   localparam int DIGITS = 5;
   localparam logic [7:0] ASCII_ZERO = 8'h30;
   // Tag field sized for the largest supported requester count (8).
   localparam int ID_MAX_W = 3;

   typedef struct packed {
      logic [7:0]          data;
      logic [ID_MAX_W-1:0] id;
      logic                last;
   } dec_byte_t;

endpackage

// File: rtl/hex2dec_arbiter_byte_fifo.sv
// rtl/hex2dec_arbiter_byte_fifo.sv - first-word fall-through FIFO with count/free
module byte_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 12,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_rdata,
   output logic [CW-1:0]    o_count,
   output logic [CW-1:0]    o_free
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;
   logic             w_rd_en;
   logic             w_wr_en;

   assign w_rd_en = i_pop & (r_count != '0);
   // A pop in the same cycle frees the slot, so a push at full is still accepted.
   assign w_wr_en = i_push & ((r_count != CW'(DEPTH)) | w_rd_en);

   always_ff @(posedge i_clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr_en, w_rd_en})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_valid = (r_count != '0);
   assign o_rdata = o_valid ? r_mem[r_rd_ptr] : '0;
   assign o_count = r_count;
   assign o_free  = CW'(DEPTH) - r_count;

endmodule

// File: rtl/hex2dec_arbiter.sv
// rtl/hex2dec_arbiter.sv - round-robin share of one hex2dec converter; HEX2DEC_ARB_LZ_SUPPRESS_EN drops leading zeros
module hex2dec_arbiter
   import hex2dec_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int FIFO_DEPTH = 8,
   localparam int ID_W      = $clog2(NUM_REQ)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [NUM_REQ-1:0]    i_req_valid,
   input  logic [NUM_REQ*16-1:0] i_req_data,
   output logic [NUM_REQ-1:0]    o_req_ready,
   output logic                  o_conv_start,
   output logic [15:0]           o_conv_hex_data,
   input  logic                  i_conv_ready,
   input  logic                  i_conv_valid,
   input  logic [7:0]            i_conv_ascii,
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic [7:0]            o_out_data,
   output logic [ID_W-1:0]       o_out_id,
   output logic                  o_out_last
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   arb_state_t         r_state;
   arb_state_t         w_state_nxt;
   logic [NUM_REQ-1:0] r_req_ready;
   logic [NUM_REQ-1:0] w_req_ready_nxt;
   logic               r_conv_start;
   logic               w_conv_start_nxt;
   logic [15:0]        r_conv_hex_data;
   logic [ID_W-1:0]    r_last_id;
   logic [ID_W-1:0]    r_cur_id;
   logic [2:0]         r_dig_cnt;
   logic [ID_W-1:0]    w_cand;
   logic [ID_W-1:0]    w_win_id;
   logic               w_win_found;
   logic [15:0]        w_win_data;
   logic               w_grant;
   logic               w_last;
   logic               w_keep;
   logic               w_push;
   dec_byte_t          w_push_byte;
   dec_byte_t          w_head;
   logic [CW-1:0]      w_fifo_count;
   logic [CW-1:0]      w_fifo_free;
   logic               w_unused;

   // Search upward from the requester after the last one served.
   always_comb begin
      w_cand      = '0;
      w_win_id    = '0;
      w_win_found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_cand = ID_W'((int'(r_last_id) + k) % NUM_REQ);
         if (!w_win_found && i_req_valid[w_cand]) begin
            w_win_found = 1'b1;
            w_win_id    = w_cand;
         end
      end
   end

   always_comb begin
      w_win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (ID_W'(i) == w_win_id) w_win_data = i_req_data[16*i +: 16];
      end
   end

   // Five free slots are reserved up front because the converter cannot be stalled.
   assign w_grant = (r_state == IDLE) & w_win_found & i_conv_ready
                  & (w_fifo_free >= CW'(DIGITS));
   assign w_last  = (r_dig_cnt == 3'(DIGITS - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_grant) w_state_nxt = START;
         START:   w_state_nxt = COLLECT;
         COLLECT: if (i_conv_valid && w_last) w_state_nxt = RELEASE;
         RELEASE: if (i_conv_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_req_ready_nxt = '0;
      if (w_grant) w_req_ready_nxt[w_win_id] = 1'b1;
      w_conv_start_nxt = (r_state == START);
      w_push           = (r_state == COLLECT) & i_conv_valid & w_keep;
   end

`ifdef HEX2DEC_ARB_LZ_SUPPRESS_EN
   logic r_seen_nz;

   always_ff @(posedge i_clk) begin
      if (i_rst || w_grant)                                  r_seen_nz <= 1'b0;
      else if (w_push && (i_conv_ascii != ASCII_ZERO))       r_seen_nz <= 1'b1;
   end

   assign w_keep = r_seen_nz | (i_conv_ascii != ASCII_ZERO) | w_last;
`else
   assign w_keep = 1'b1;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_req_ready     <= '0;
         r_conv_start    <= 1'b0;
         r_conv_hex_data <= '0;
         r_cur_id        <= '0;
         r_last_id       <= ID_W'(NUM_REQ - 1);
         r_dig_cnt       <= '0;
      end else begin
         r_req_ready  <= w_req_ready_nxt;
         r_conv_start <= w_conv_start_nxt;
         if (w_grant) begin
            r_conv_hex_data <= w_win_data;
            r_cur_id        <= w_win_id;
            r_dig_cnt       <= '0;
         end else if (r_state == COLLECT && i_conv_valid) begin
            r_dig_cnt <= r_dig_cnt + 1'b1;
         end
         if (r_state == RELEASE) r_last_id <= r_cur_id;
      end
   end

   assign w_push_byte = '{data: i_conv_ascii, id: ID_MAX_W'(r_cur_id), last: w_last};

   byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(dec_byte_t))
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push),
      .i_wdata (w_push_byte),
      .i_pop   (i_out_ready),
      .o_valid (o_out_valid),
      .o_rdata (w_head),
      .o_count (w_fifo_count),
      .o_free  (w_fifo_free)
   );

   assign o_req_ready     = r_req_ready;
   assign o_conv_start    = r_conv_start;
   assign o_conv_hex_data = r_conv_hex_data;
   assign o_out_data      = w_head.data;
   assign o_out_id        = w_head.id[ID_W-1:0];
   assign o_out_last      = w_head.last;
   assign w_unused        = ^{w_head.id, w_fifo_count};

endmodule

// File: tb/tb_hex2dec_arbiter.sv
// tb/tb_hex2dec_arbiter.sv - self-checking bench for hex2dec_arbiter
module tb_hex2dec_arbiter;
   localparam int NUM_REQ    = 4;
   localparam int FIFO_DEPTH = 8;
   localparam int ID_W       = 2;
`ifdef HEX2DEC_ARB_LZ_SUPPRESS_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] d;
      logic [2:0] id;
      logic       last;
   } tb_byte_t;

   typedef struct {
      int          id;
      int unsigned value;
      logic [39:0] s;
      int          len;
   } vec_t;

   logic                  clk;
   logic                  i_rst;
   logic [NUM_REQ-1:0]    i_req_valid;
   logic [NUM_REQ*16-1:0] i_req_data;
   logic [NUM_REQ-1:0]    o_req_ready;
   logic                  o_conv_start;
   logic [15:0]           o_conv_hex_data;
   logic                  i_conv_ready;
   logic                  i_conv_valid;
   logic [7:0]            i_conv_ascii;
   logic                  o_out_valid;
   logic                  i_out_ready;
   logic [7:0]            o_out_data;
   logic [ID_W-1:0]       o_out_id;
   logic                  o_out_last;

   hex2dec_arbiter #(.NUM_REQ(NUM_REQ), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .i_req_data(i_req_data),
      .o_req_ready(o_req_ready), .o_conv_start(o_conv_start), .o_conv_hex_data(o_conv_hex_data),
      .i_conv_ready(i_conv_ready), .i_conv_valid(i_conv_valid), .i_conv_ascii(i_conv_ascii),
      .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
      .o_out_id(o_out_id), .o_out_last(o_out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int m_last  = NUM_REQ - 1;
   logic [NUM_REQ-1:0] rv_prev   = '0;
   logic [NUM_REQ-1:0] drop_mask = '0;
   bit auto_drop = 1'b1;
   tb_byte_t got_q[$];
   tb_byte_t exp_q[$];
   int grant_q[$];
   int start_q[$];
   int pop_q[$];

   function automatic logic [7:0] dig(input int unsigned v, input int k);
      int unsigned p;
      p = (k == 0) ? 10000 : (k == 1) ? 1000 : (k == 2) ? 100 : (k == 3) ? 10 : 1;
      return 8'h30 + 8'((v / p) % 10);
   endfunction

   function automatic int exp_bytes(input int unsigned v, input int id, output tb_byte_t b[5]);
      int n;
      bit seen;
      logic [7:0] d;
      n = 0;
      seen = 1'b0;
      for (int k = 0; k < 5; k++) b[k] = '0;
      for (int k = 0; k < 5; k++) begin
         d = dig(v, k);
         if (!(LZ && !seen && d == 8'h30 && k != 4)) begin
            seen = 1'b1;
            b[n] = '{d: d, id: 3'(id), last: (k == 4)};
            n++;
         end
      end
      return n;
   endfunction

   // Converter model: after start, emits 5 digits MSB-first with random gaps.
   logic        m_busy;
   logic        m_valid;
   logic [7:0]  m_ascii;
   logic [15:0] m_val;
   int          cv_idx;
   bit          tb_stray;
   assign i_conv_valid = m_valid | tb_stray;
   assign i_conv_ascii = tb_stray ? 8'h37 : m_ascii;

   always @(posedge clk) begin
      if (i_rst) begin
         m_busy <= 1'b0; i_conv_ready <= 1'b1; m_valid <= 1'b0; m_ascii <= 8'h0; cv_idx <= 0;
      end else begin
         m_valid <= 1'b0;
         if (!m_busy) begin
            i_conv_ready <= 1'b1;
            if (o_conv_start) begin
               m_busy <= 1'b1; m_val <= o_conv_hex_data; cv_idx <= 0; i_conv_ready <= 1'b0;
            end
         end else if (cv_idx == 5) begin
            m_busy <= 1'b0; i_conv_ready <= 1'b1;
         end else if ($urandom_range(0, 3) != 0) begin
            m_valid <= 1'b1; m_ascii <= dig(32'(m_val), cv_idx); cv_idx <= cv_idx + 1;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: sample at negedge, keep scoreboard/grant model, return 1ns after posedge.
   task automatic step();
      tb_byte_t g, e;
      tb_byte_t b[5];
      int n, win, j;
      @(negedge clk);
      if (o_out_valid && i_out_ready) begin
         g = '{d: o_out_data, id: 3'(o_out_id), last: o_out_last};
         got_q.push_back(g);
         pop_q.push_back(cyc);
         check("byte_expected", 64'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("byte", 64'(g), 64'(e));
         end
      end
      if (o_req_ready != '0) begin
         check("ready_onehot", 64'($onehot(o_req_ready)), 1);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (o_req_ready[i]) begin
               win = -1;
               for (int k = 1; k <= NUM_REQ; k++) begin
                  j = (m_last + k) % NUM_REQ;
                  if (win < 0 && rv_prev[j]) win = j;
               end
               check("grant_rr", 64'(i), 64'(win));
               grant_q.push_back(i);
               m_last = i;
               n = exp_bytes(32'(i_req_data[16*i +: 16]), i, b);
               for (int k = 0; k < n; k++) exp_q.push_back(b[k]);
               if (auto_drop) drop_mask[i] = 1'b1;
            end
         end
      end
      if (o_conv_start) start_q.push_back(cyc);
      rv_prev = i_req_valid;
      @(posedge clk);
      cyc++;
      #1;
      i_req_valid = i_req_valid & ~drop_mask;
      drop_mask = '0;
   endtask

   task automatic clear_q();
      got_q.delete(); exp_q.delete(); grant_q.delete(); start_q.delete(); pop_q.delete();
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      i_req_valid = '0;
      i_out_ready = 1'b1;
      step();
      step();
      i_rst = 1'b0;
      clear_q();
      m_last = NUM_REQ - 1;
      rv_prev = '0;
      auto_drop = 1'b1;
   endtask

   task automatic request(input int id, input int unsigned value);
      i_req_data[16*id +: 16] = 16'(value);
      i_req_valid[id] = 1'b1;
   endtask

   task automatic drain(input int budget);
      for (int t = 0; t < budget && (exp_q.size() != 0 || i_req_valid != '0); t++) step();
      check("drain_done", 64'(exp_q.size() == 0 && i_req_valid == '0), 1);
      repeat (8) step();
   endtask

   vec_t tbl[5];
   logic [39:0] s;
   tb_byte_t exb;
   tb_byte_t bb[5];
   int nexp;

   initial begin
      i_rst = 1'b1; i_req_valid = '0; i_req_data = '0; i_out_ready = 1'b1; tb_stray = 1'b0;
      tbl[0] = '{1, 12345, "12345", 5};
      tbl[2] = '{3, 65535, "65535", 5};
      if (LZ) begin
         tbl[1] = '{0, 0,   {32'd0, "0"},   1};
         tbl[3] = '{2, 100, {16'd0, "100"}, 3};
         tbl[4] = '{0, 7,   {32'd0, "7"},   1};
      end else begin
         tbl[1] = '{0, 0,   "00000", 5};
         tbl[3] = '{2, 100, "00100", 5};
         tbl[4] = '{0, 7,   "00007", 5};
      end

      // Reset values
      step();
      check("rst_req_ready", 64'(o_req_ready), 0);
      check("rst_conv_start", 64'(o_conv_start), 0);
      check("rst_conv_hex", 64'(o_conv_hex_data), 0);
      check("rst_out_valid", 64'(o_out_valid), 0);
      check("rst_out_data", 64'(o_out_data), 0);
      check("rst_out_id", 64'(o_out_id), 0);
      check("rst_out_last", 64'(o_out_last), 0);
      do_reset();

      // Table-driven single conversions
      for (int v = 0; v < 5; v++) begin
         got_q.delete(); grant_q.delete();
         request(tbl[v].id, tbl[v].value);
         for (int t = 0; t < 100 && got_q.size() < tbl[v].len; t++) step();
         repeat (6) step();
         check("vec_len", 64'(got_q.size()), 64'(tbl[v].len));
         check("vec_grants", 64'(grant_q.size()), 1);
         s = tbl[v].s;
         for (int k = 0; k < tbl[v].len && k < got_q.size(); k++) begin
            exb = '{d: s[8*(tbl[v].len-1-k) +: 8], id: 3'(tbl[v].id), last: (k == tbl[v].len-1)};
            check("vec_byte", 64'(got_q[k]), 64'(exb));
         end
      end

      // Requesters 0 and 2 held together: alternate, no interleaving
      do_reset();
      auto_drop = 1'b0;
      request(0, 31415);
      request(2, 40000);
      for (int t = 0; t < 300 && grant_q.size() < 4; t++) step();
      i_req_valid = '0;
      auto_drop = 1'b1;
      drain(300);
      check("hold_grants", 64'(grant_q.size()), 4);
      for (int k = 0; k < 4 && k < grant_q.size(); k++) check("hold_order", 64'(grant_q[k]), 64'((k % 2) * 2));
      check("hold_bytes", 64'(got_q.size()), 20);
      for (int k = 0; k < got_q.size(); k++) begin
         check("hold_id", 64'(got_q[k].id), 64'(((k / 5) % 2) * 2));
         check("hold_last", 64'(got_q[k].last), 64'((k % 5) == 4));
      end

      // Backpressure: one conversion while free < 5, prompt restart afterwards
      do_reset();
      i_out_ready = 1'b0;
      request(1, 11111); request(2, 22222); request(3, 33333);
      repeat (60) step();
      check("bp_starts", 64'(start_q.size()), 1);
      check("bp_grants", 64'(grant_q.size()), 1);
      check("bp_out_valid", 64'(o_out_valid), 1);
      start_q.delete(); pop_q.delete();
      i_out_ready = 1'b1;
      drain(300);
      check("bp_starts_after", 64'(start_q.size()), 2);
      if (start_q.size() > 0 && pop_q.size() > 1)
         check("bp_restart_lat", 64'((start_q[0] - (pop_q[1] + 1)) inside {[1:2]}), 1);
      check("bp_order", 64'(grant_q.size() == 3 && grant_q[1] == 2 && grant_q[2] == 3), 1);

      // Reset during COLLECT after two digits
      do_reset();
      i_out_ready = 1'b0;
      request(2, 4321);
      for (int t = 0; t < 60 && cv_idx < 2; t++) step();
      check("mid_reached", 64'(cv_idx >= 2), 1);
      i_rst = 1'b1;
      step();
      i_rst = 1'b0;
      check("mid_out_valid", 64'(o_out_valid), 0);
      check("mid_conv_start", 64'(o_conv_start), 0);
      clear_q(); m_last = NUM_REQ - 1; i_req_valid = '0;
      repeat (3) step();
      check("mid_no_residual", 64'(o_out_valid), 0);
      i_out_ready = 1'b1;
      request(1, 909);
      drain(200);
      nexp = exp_bytes(909, 1, bb);
      check("mid_after_len", 64'(got_q.size()), 64'(nexp));

      // Stray conv_valid in IDLE
      got_q.delete();
      tb_stray = 1'b1;
      repeat (3) step();
      tb_stray = 1'b0;
      repeat (3) step();
      check("stray_no_push", 64'(got_q.size()), 0);
      check("stray_out_valid", 64'(o_out_valid), 0);

      // Random traffic against the scoreboard
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!i_req_valid[i] && $urandom_range(0, 7) == 0) begin
               case ($urandom_range(0, 7))
                  0:       request(i, 0);
                  1:       request(i, 65535);
                  default: request(i, $urandom_range(0, 65535));
               endcase
            end
         end
         i_out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      i_out_ready = 1'b1;
      drain(1000);
      check("rnd_activity", 64'(grant_q.size() > 20), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
